// File: rtl/hc_csr_bank_if.sv
// hc_csr_bank_if: CCI-P MMIO request (c0) and read-response (c2) signal bundle.
// The shim side drives requests as master; the CSR bank answers as slave.
interface hc_csr_bank_if;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: HardCloud MMIO CSR bank. Holds DSM base, control register and
// NUM_BUFFERS {address,size} descriptors, runs the AFU control FSM and answers
// MMIO reads one cycle after the request.
// Optional build macro HC_CSR_STATUS_EN: read-only status word at byte 0x100
// (FSM state in [1:0], saturating run-cycle counter in [63:32]).
module hc_csr_bank #(
    parameter int          NUM_BUFFERS = 4,
    parameter logic [15:0] BUF_BASE    = 16'h120,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0
) (
    input  logic                      clk,
    input  logic                      SoftReset,
    hc_csr_bank_if.slave              mmio,
    output logic [63:0]               dsm_base,
    output logic [64*NUM_BUFFERS-1:0] buf_addr,
    output logic [32*NUM_BUFFERS-1:0] buf_size,
    output logic                      afu_reset,
    output logic                      start,
    output logic                      running,
    output logic                      stop,
    input  logic                      done
);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Device feature header: AFU type, end-of-list set, no next feature.
    localparam logic [63:0] DFH_VALUE   = 64'h1000_0100_0000_0000;
    localparam logic [17:0] ADDR_DFH    = 18'h000;
    localparam logic [17:0] ADDR_ID_L   = 18'h008;
    localparam logic [17:0] ADDR_ID_H   = 18'h010;
    localparam logic [17:0] ADDR_STATUS = 18'h100;
    localparam logic [17:0] ADDR_DSM    = 18'h110;
    localparam logic [17:0] ADDR_CTRL   = 18'h118;
    localparam logic [17:0] DESC_BASE   = {2'b00, BUF_BASE};

    localparam logic [31:0] CTRL_RESET = 32'd0;
    localparam logic [31:0] CTRL_INIT  = 32'd1;
    localparam logic [31:0] CTRL_START = 32'd3;
    localparam logic [31:0] CTRL_STOP  = 32'd7;

    state_t      state_reg;
    logic        afu_reset_reg;
    logic        start_reg;
    logic        stop_reg;
    logic        running_reg;
    logic [31:0] ctrl_reg;
    logic [63:0] dsm_reg;

    logic        rsp_valid_reg;
    logic [8:0]  rsp_tid_reg;
    logic [63:0] rsp_data_reg;

    // Request decode: byte address of the enclosing qword plus which half is addressed.
    logic [17:0] qw_addr;
    logic        hi_half;
    logic        len_8b;
    logic        access_ok;
    logic        wr_fire;
    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic        go_run;
    logic        dsm_we;

    assign qw_addr    = {mmio.mmio_addr[15:1], 3'b000};
    assign hi_half    = mmio.mmio_addr[0];
    assign len_8b     = (mmio.mmio_len == 2'd1);
    // 8B accesses must be qword aligned; anything else is treated as unmapped.
    assign access_ok  = (mmio.mmio_len == 2'd0) || (len_8b && !hi_half);
    assign wr_fire    = mmio.mmio_wr_valid && access_ok;
    // Control lives in the low 32 bits only; a 4B write to its upper half is dropped.
    assign ctrl_we    = wr_fire && (qw_addr == ADDR_CTRL) && !hi_half;
    assign ctrl_wdata = mmio.mmio_wr_data[31:0];
    assign go_run     = ctrl_we && (ctrl_wdata == CTRL_START) &&
                        ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign dsm_we     = wr_fire && (qw_addr == ADDR_DSM) && !running_reg;

    // Apply an 8B write or a 4B write into the addressed half of a 64-bit register.
    function automatic logic [63:0] merge_write(input logic [63:0] old_value,
                                                input logic [63:0] wr_data,
                                                input logic        full,
                                                input logic        upper);
        if (full)
            return wr_data;
        else if (upper)
            return {wr_data[31:0], old_value[31:0]};
        else
            return {old_value[63:32], wr_data[31:0]};
    endfunction

    // Per-descriptor read contribution; zero unless that descriptor is addressed.
    logic [NUM_BUFFERS-1:0][63:0] desc_rd_data;

    generate
        for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_desc
            localparam logic [17:0] ADDR_A = DESC_BASE + 18'(16 * gi);
            localparam logic [17:0] ADDR_S = ADDR_A + 18'd8;

            logic [63:0] addr_reg;
            logic [31:0] size_reg;
            logic        addr_hit;
            logic        size_hit;

            assign addr_hit = (qw_addr == ADDR_A);
            assign size_hit = (qw_addr == ADDR_S);

            // Descriptor registers, frozen while the datapath is running.
            always_ff @(posedge clk or posedge SoftReset) begin
                if (SoftReset) begin
                    addr_reg <= '0;
                    size_reg <= '0;
                end else if (wr_fire && !running_reg) begin
                    if (addr_hit)
                        addr_reg <= merge_write(addr_reg, mmio.mmio_wr_data, len_8b, hi_half);
                    if (size_hit && !hi_half)
                        size_reg <= mmio.mmio_wr_data[31:0];
                end
            end

            assign buf_addr[64*gi +: 64] = addr_reg;
            assign buf_size[32*gi +: 32] = size_reg;
            assign desc_rd_data[gi] = addr_hit ? addr_reg :
                                      size_hit ? {32'd0, size_reg} : 64'd0;
        end
    endgenerate

    logic [63:0] status_word;

`ifdef HC_CSR_STATUS_EN
    logic [31:0] cycle_cnt_reg;

    // Run-cycle counter: cleared on start, counts while running, saturates.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset)
            cycle_cnt_reg <= '0;
        else if (go_run)
            cycle_cnt_reg <= '0;
        else if ((state_reg == S_RUN) && (cycle_cnt_reg != 32'hFFFF_FFFF))
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end

    assign status_word = {cycle_cnt_reg, 30'd0, 2'(state_reg)};
`else
    assign status_word = 64'd0;
`endif

    // DSM base register, frozen while the datapath is running.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset)
            dsm_reg <= '0;
        else if (dsm_we)
            dsm_reg <= merge_write(dsm_reg, mmio.mmio_wr_data, len_8b, hi_half);
    end

    // Control FSM with the control register and all FSM outputs registered.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_reg     <= S_RST;
            ctrl_reg      <= '0;
            afu_reset_reg <= 1'b1;
            start_reg     <= 1'b0;
            stop_reg      <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            stop_reg  <= 1'b0;
            if (ctrl_we) begin
                // A control write in the same cycle as done wins over done.
                ctrl_reg <= ctrl_wdata;
                if (ctrl_wdata == CTRL_RESET) begin
                    state_reg     <= S_RST;
                    afu_reset_reg <= 1'b1;
                    running_reg   <= 1'b0;
                end else if ((ctrl_wdata == CTRL_INIT) && (state_reg == S_RST)) begin
                    state_reg     <= S_IDLE;
                    afu_reset_reg <= 1'b0;
                end else if (go_run) begin
                    state_reg   <= S_RUN;
                    running_reg <= 1'b1;
                    start_reg   <= 1'b1;
                end else if ((ctrl_wdata == CTRL_STOP) && (state_reg == S_RUN)) begin
                    state_reg   <= S_IDLE;
                    running_reg <= 1'b0;
                    stop_reg    <= 1'b1;
                end
            end else if (done && (state_reg == S_RUN)) begin
                state_reg   <= S_DONE;
                running_reg <= 1'b0;
            end
        end
    end

    // Read mux over the register map, using pre-write register values.
    logic [63:0] rd_qword;
    logic [63:0] rd_value;

    always_comb begin
        rd_qword = 64'd0;
        for (int i = 0; i < NUM_BUFFERS; i++)
            rd_qword = rd_qword | desc_rd_data[i];
        if (qw_addr == ADDR_DFH)
            rd_qword = DFH_VALUE;
        else if (qw_addr == ADDR_ID_L)
            rd_qword = AFU_ID_L;
        else if (qw_addr == ADDR_ID_H)
            rd_qword = AFU_ID_H;
        else if (qw_addr == ADDR_STATUS)
            rd_qword = status_word;
        else if (qw_addr == ADDR_DSM)
            rd_qword = dsm_reg;
        else if (qw_addr == ADDR_CTRL)
            rd_qword = {32'd0, ctrl_reg};

        rd_value = 64'd0;
        if (access_ok) begin
            if (len_8b)
                rd_value = rd_qword;
            else if (hi_half)
                rd_value = {32'd0, rd_qword[63:32]};
            else
                rd_value = {32'd0, rd_qword[31:0]};
        end
    end

    // Read response, returned exactly one cycle after the request.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            rsp_valid_reg <= 1'b0;
            rsp_tid_reg   <= '0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= mmio.mmio_rd_valid;
            rsp_tid_reg   <= mmio.mmio_tid;
            if (mmio.mmio_rd_valid)
                rsp_data_reg <= rd_value;
        end
    end

    assign mmio.rsp_valid = rsp_valid_reg;
    assign mmio.rsp_tid   = rsp_tid_reg;
    assign mmio.rsp_data  = rsp_data_reg;
    assign dsm_base       = dsm_reg;
    assign afu_reset      = afu_reset_reg;
    assign start          = start_reg;
    assign stop           = stop_reg;
    assign running        = running_reg;

endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank: directed and randomized MMIO traffic against a register-map
// model of the CSR bank, compared on every falling clock edge.
module tb_hc_csr_bank;
    localparam int          NB    = 4;
    localparam int          DESC0 = 'h120;
    localparam logic [63:0] ID_L  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] ID_H  = 64'h0FED_CBA9_8765_4321;
    localparam logic [63:0] DFH   = 64'h1000_0100_0000_0000;

    logic              clk = 1'b0;
    logic              SoftReset;
    logic              done_in;
    logic [63:0]       dsm_base;
    logic [64*NB-1:0]  buf_addr;
    logic [32*NB-1:0]  buf_size;
    logic              afu_reset, start, running, stop;

    hc_csr_bank_if bus();

    hc_csr_bank #(
        .NUM_BUFFERS(NB), .BUF_BASE(16'h120), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)
    ) dut (
        .clk(clk), .SoftReset(SoftReset), .mmio(bus), .dsm_base(dsm_base),
        .buf_addr(buf_addr), .buf_size(buf_size), .afu_reset(afu_reset),
        .start(start), .running(running), .stop(stop), .done(done_in)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: register contents by name, FSM state as 0..3 (RST,IDLE,RUN,DONE).
    logic [63:0] m_dsm;
    logic [31:0] m_ctrl;
    logic [63:0] m_addr [NB];
    logic [31:0] m_size [NB];
    int          m_state;
    logic        m_start, m_stop;
    logic [31:0] m_cnt;
    logic        m_rsp_valid;
    logic [8:0]  m_rsp_tid;
    logic [63:0] m_rsp_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dsm = '0; m_ctrl = '0; m_state = 0; m_start = 0; m_stop = 0; m_cnt = '0;
        m_rsp_valid = 0; m_rsp_tid = '0; m_rsp_data = '0;
        for (int i = 0; i < NB; i++) begin
            m_addr[i] = '0;
            m_size[i] = '0;
        end
    endtask

    function automatic logic [63:0] model_qword(input int b);
        if (b == 0) return DFH;
        if (b == 'h8) return ID_L;
        if (b == 'h10) return ID_H;
`ifdef HC_CSR_STATUS_EN
        if (b == 'h100) return {m_cnt, 30'd0, 2'(m_state)};
`endif
        if (b == 'h110) return m_dsm;
        if (b == 'h118) return {32'd0, m_ctrl};
        if (b >= DESC0 && b < DESC0 + 16 * NB) begin
            if ((b - DESC0) % 16 == 0) return m_addr[(b - DESC0) / 16];
            return {32'd0, m_size[(b - DESC0) / 16]};
        end
        return 64'd0;
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] a, input logic [1:0] len);
        int b = int'(a) * 4;
        logic [63:0] q = model_qword(b - b % 8);
        if (len == 2'd1 && !a[0]) return q;
        if (len != 2'd0) return 64'd0;
        return a[0] ? {32'd0, q[63:32]} : {32'd0, q[31:0]};
    endfunction

    function automatic logic [63:0] merged(input logic [63:0] old, input logic [63:0] d,
                                           input logic [1:0] len, input logic up);
        if (len == 2'd1) return d;
        return up ? {d[31:0], old[31:0]} : {old[63:32], d[31:0]};
    endfunction

    // One clock edge of the register map, applied from the request visible at the edge.
    task automatic model_step();
        logic [15:0] a;
        logic [1:0]  len;
        logic [63:0] d;
        logic [31:0] cv;
        logic        up, ok, ctrl_wr;
        int          b, qb, pre;
        if (SoftReset) begin
            model_reset();
            return;
        end
        a = bus.mmio_addr; len = bus.mmio_len; d = bus.mmio_wr_data;
        b = int'(a) * 4; qb = b - b % 8; up = a[0];
        ok = (len == 2'd0) || (len == 2'd1 && !up);
        pre = m_state;
        m_rsp_valid = bus.mmio_rd_valid;
        m_rsp_tid = bus.mmio_tid;
        if (bus.mmio_rd_valid) m_rsp_data = model_read(a, len);
        m_start = 0; m_stop = 0; ctrl_wr = 0; cv = '0;
        if (bus.mmio_wr_valid && ok) begin
            if (qb == 'h118) begin
                if (!up) begin ctrl_wr = 1; cv = d[31:0]; m_ctrl = cv; end
            end else if (qb == 'h110) begin
                if (pre != 2) m_dsm = merged(m_dsm, d, len, up);
            end else if (qb >= DESC0 && qb < DESC0 + 16 * NB && pre != 2) begin
                if ((qb - DESC0) % 16 == 0)
                    m_addr[(qb - DESC0) / 16] = merged(m_addr[(qb - DESC0) / 16], d, len, up);
                else if (!up)
                    m_size[(qb - DESC0) / 16] = d[31:0];
            end
        end
        if (ctrl_wr) begin
            if (cv == 0) m_state = 0;
            else if (cv == 1 && pre == 0) m_state = 1;
            else if (cv == 3 && (pre == 1 || pre == 3)) begin m_state = 2; m_start = 1; end
            else if (cv == 7 && pre == 2) begin m_state = 1; m_stop = 1; end
        end else if (done_in && pre == 2) begin
            m_state = 3;
        end
        if (m_start) m_cnt = '0;
        else if (pre == 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [15:0] dw(input int byte_addr);
        return 16'(byte_addr / 4);
    endfunction

    task automatic mmio_wr(input int b, input logic [1:0] len, input logic [63:0] d);
        bus.mmio_wr_valid = 1; bus.mmio_addr = dw(b); bus.mmio_len = len; bus.mmio_wr_data = d;
        tick();
        bus.mmio_wr_valid = 0;
    endtask

    task automatic mmio_rd(input int b, input logic [1:0] len, input logic [8:0] tid);
        bus.mmio_rd_valid = 1; bus.mmio_addr = dw(b); bus.mmio_len = len; bus.mmio_tid = tid;
        tick();
        bus.mmio_rd_valid = 0;
    endtask

    task automatic do_reset();
        SoftReset = 1;
        model_reset();
        repeat (2) tick();
        SoftReset = 0;
    endtask

    // Compare process: every falling edge, all outputs against the model.
    initial forever begin
        @(negedge clk);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_valid));
        if (m_rsp_valid) begin
            check("rsp_tid", 64'(bus.rsp_tid), 64'(m_rsp_tid));
            check("rsp_data", bus.rsp_data, m_rsp_data);
        end
        check("afu_reset", 64'(afu_reset), 64'(m_state == 0));
        check("running", 64'(running), 64'(m_state == 2));
        check("start", 64'(start), 64'(m_start));
        check("stop", 64'(stop), 64'(m_stop));
        check("dsm_base", dsm_base, m_dsm);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("buf_addr%0d", i), buf_addr[64*i +: 64], m_addr[i]);
            check($sformatf("buf_size%0d", i), 64'(buf_size[32*i +: 32]), 64'(m_size[i]));
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int rand_qword();
        case ($urandom_range(0, 9))
            0: return 'h0;
            1: return 'h8;
            2: return 'h10;
            3: return 'h100;
            4: return 'h110;
            5, 6: return 'h118;
            7, 8: return DESC0 + 8 * int'($urandom_range(0, 2 * NB - 1));
            default: return 8 * int'($urandom_range(0, 'h7F));
        endcase
    endfunction

    function automatic logic [31:0] rand_ctrl();
        case ($urandom_range(0, 19))
            0, 1: return 32'd0;
            2, 3, 4, 5, 6: return 32'd1;
            7, 8, 9, 10, 11, 12: return 32'd3;
            13, 14, 15, 16: return 32'd7;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.mmio_wr_valid = 0; bus.mmio_rd_valid = 0; bus.mmio_addr = '0;
        bus.mmio_len = '0; bus.mmio_tid = '0; bus.mmio_wr_data = '0; done_in = 0;
        SoftReset = 1;
        model_reset();
        repeat (3) tick();
        SoftReset = 0;

        // Reset state.
        check("lit_reset_afu_reset", 64'(afu_reset), 64'd1);
        check("lit_reset_running", 64'(running), 64'd0);
        check("lit_reset_dsm", dsm_base, 64'd0);

        // AFU ID low read, tid 5, one-cycle latency.
        mmio_rd('h008, 2'd1, 9'd5);
        check("lit_id_valid", 64'(bus.rsp_valid), 64'd1);
        check("lit_id_tid", 64'(bus.rsp_tid), 64'd5);
        check("lit_id_data", bus.rsp_data, 64'h1234_5678_9ABC_DEF0);
        tick();
        check("lit_id_valid_drop", 64'(bus.rsp_valid), 64'd0);
        mmio_rd('h000, 2'd1, 9'd6);
        check("lit_dfh", bus.rsp_data, 64'h1000_0100_0000_0000);

        // Descriptor 1 address: full write, then 4B write to upper half.
        mmio_wr('h130, 2'd1, 64'hDEAD_BEEF_0000_1000);
        check("lit_desc1_full", buf_addr[127:64], 64'hDEAD_BEEF_0000_1000);
        mmio_wr('h134, 2'd0, 64'h0000_0000_0000_0001);
        check("lit_desc1_upper", buf_addr[127:64], 64'h0000_0001_0000_1000);
        mmio_rd('h134, 2'd0, 9'd7);
        check("lit_desc1_rd_hi", bus.rsp_data, 64'h0000_0000_0000_0001);

        // Bring up and run; descriptor locked; stop.
        mmio_wr('h118, 2'd1, 64'd1);
        check("lit_init_afu_reset", 64'(afu_reset), 64'd0);
        mmio_wr('h118, 2'd1, 64'd3);
        check("lit_start_pulse", 64'(start), 64'd1);
        check("lit_start_running", 64'(running), 64'd1);
        mmio_wr('h120, 2'd1, 64'h5555);
        check("lit_start_pulse_end", 64'(start), 64'd0);
        check("lit_desc0_locked", buf_addr[63:0], 64'd0);
        mmio_wr('h118, 2'd1, 64'd7);
        check("lit_stop_pulse", 64'(stop), 64'd1);
        check("lit_stop_running", 64'(running), 64'd0);

        // done and ctrl=0 in the same cycle: write wins.
        mmio_wr('h118, 2'd1, 64'd3);
        bus.mmio_wr_valid = 1; bus.mmio_addr = dw('h118); bus.mmio_len = 2'd1;
        bus.mmio_wr_data = 64'd0; done_in = 1;
        tick();
        bus.mmio_wr_valid = 0; done_in = 0;
        check("lit_prio_afu_reset", 64'(afu_reset), 64'd1);
        check("lit_prio_running", 64'(running), 64'd0);

        // Unmapped read.
        mmio_rd('h1F8, 2'd1, 9'd9);
        check("lit_unmapped", bus.rsp_data, 64'd0);

        // SoftReset during RUN with a read in flight.
        mmio_wr('h110, 2'd1, 64'hABCD);
        mmio_wr('h118, 2'd1, 64'd1);
        mmio_wr('h118, 2'd1, 64'd3);
        bus.mmio_rd_valid = 1; bus.mmio_addr = dw('h008); bus.mmio_len = 2'd1; bus.mmio_tid = 9'd11;
        tick();
        bus.mmio_rd_valid = 0;
        SoftReset = 1;
        model_reset();
        #1;
        check("lit_srst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("lit_srst_afu_reset", 64'(afu_reset), 64'd1);
        check("lit_srst_running", 64'(running), 64'd0);
        check("lit_srst_dsm", dsm_base, 64'd0);
        check("lit_srst_desc1", buf_addr[127:64], 64'd0);
        tick();
        tick();
        SoftReset = 0;

        // Status word (or its absence).
        mmio_wr('h118, 2'd1, 64'd1);
        mmio_wr('h118, 2'd1, 64'd3);
        repeat (99) tick();
        done_in = 1;
        tick();
        done_in = 0;
        mmio_rd('h100, 2'd1, 9'd12);
`ifdef HC_CSR_STATUS_EN
        check("lit_status", bus.rsp_data, 64'h0000_0064_0000_0003);
`else
        check("lit_status_absent", bus.rsp_data, 64'd0);
`endif

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                int qb = rand_qword();
                logic up = ($urandom_range(0, 3) == 0);
                bus.mmio_addr = dw(qb) + 16'(up);
                bus.mmio_len = 2'($urandom_range(0, 1));
                bus.mmio_tid = 9'($urandom);
                bus.mmio_wr_valid = $urandom_range(0, 1) == 1;
                bus.mmio_rd_valid = $urandom_range(0, 1) == 1;
                bus.mmio_wr_data = {$urandom, $urandom};
                if (qb == 'h118) bus.mmio_wr_data[31:0] = rand_ctrl();
                done_in = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        bus.mmio_wr_valid = 0; bus.mmio_rd_valid = 0; done_in = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
